icache: RTL
===========

Name: icache

Overview:
- Direct-mapped instruction cache between the decoder's fetch port and the memory controller's word-read port.
- Decoder side is a request/ready pair: request held high until a one-cycle ready pulse.
- Hits are served in one cycle. Misses forward a word read to the memory controller, fill the line, then respond.
- Instructions are 32-bit and word-aligned; one instruction per line.

Parameters:
INDEX_WIDTH, 6, log2 of line count (64 lines); tag width = 30 - INDEX_WIDTH

Ports:
clk_in  input  1  clock
rst_in  input  1  synchronous active-high reset
rdy_in  input  1  global enable; when low, all state and outputs hold
flush  input  1  mispredict flush; abandons the current decoder request
in_en  input  1  fetch request from decoder, held until in_rdy
in_addr  input  32  fetch address; bits [1:0] ignored
in_rdy  output  1  registered one-cycle pulse: in_data valid
in_data  output  32  instruction word
mem_en  output  1  word-read request to memory controller, held until mem_rdy
mem_addr  output  32  word-aligned miss address ({in_addr[31:2],2'b00})
mem_rdy  input  1  one-cycle pulse: mem_data valid
mem_data  input  32  word read from memory

Behaviour:
- Index = addr[INDEX_WIDTH+1:2]; tag = addr[31:INDEX_WIDTH+2]. Storage per line: valid bit, tag, 32-bit data.
- Reset: all valid bits = 0, state = IDLE, in_rdy = 0, in_data = 0, mem_en = 0, mem_addr = 0. Tag/data arrays need no reset.
- rdy_in low (and not in reset): nothing changes, including in_rdy.
- Reset has priority over rdy_in and flush. Reset mid-miss drops mem_en immediately; the memory controller is reset in the same cycle.
- Default every active cycle: in_rdy <= 0.
- State IDLE:
  - Accepts a request only when in_en = 1, flush = 0 and in_rdy = 0 (the in_rdy term blocks a double pulse, since the decoder still drives in_en during the ready cycle).
  - Hit (valid and tag match): in_rdy <= 1, in_data <= line data. Latency: request seen at edge N, pulse visible in cycle N+1.
  - Miss: mem_en <= 1, mem_addr <= word address, latch the request address, go to MISS.
- State MISS:
  - Hold mem_en and mem_addr stable.
  - On mem_rdy: write line (valid = 1, tag, data), mem_en <= 0, in_rdy <= 1, in_data <= mem_data, go to IDLE.
  - Flush with mem_rdy = 0: go to DRAIN. Memory transactions are never aborted.
  - Flush and mem_rdy in the same cycle: fill the line, no in_rdy pulse, go to IDLE.
- State DRAIN:
  - Keep mem_en until mem_rdy.
  - On mem_rdy: fill the line (the data is correct for that address), mem_en <= 0, no response, go to IDLE.
  - Further flushes are ignored.
- Flush in IDLE: no request accepted that cycle, in_rdy forced 0. The cache contents are not invalidated by flush.
- Back-to-back hits: at most one pulse every 2 cycles, set by the in_rdy gating.
- The decoder changes in_addr only after in_rdy or flush. The cache uses the latched miss address, never live in_addr, while in MISS or DRAIN.
- The block holds no write path; self-modifying code is unsupported.

Optional Feature:
ICACHE_STATS_EN
- Defined:
  - Adds outputs stat_hits[31:0] and stat_misses[31:0], reset to 0.
  - stat_hits increments on each accepted hit; stat_misses on each IDLE→MISS transition.
  - Both saturate at 32'hFFFFFFFF and hold under rdy_in low.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared params header:
  - ICACHE_INDEX_WIDTH default.
  - State encodings ICACHE_IDLE = 0, ICACHE_MISS = 1, ICACHE_DRAIN = 2 (2-bit).
  - Tag-width macro derived from the index width.
- One natural sub-module: icache_array. It holds valid/tag/data storage with a combinational read port (index → valid, tag, data) and a synchronous write port (we, index, tag, data), plus the synchronous valid clear on reset. The FSM stays in icache.

Test Plan:
- Cold miss: reset; in_en = 1, in_addr = 0x00000010; memory returns mem_rdy with 0x00500093 four cycles later → mem_addr = 0x10, one in_rdy pulse with in_data = 0x00500093 the cycle after mem_rdy, mem_en low afterwards.
- Hit: repeat the request to 0x10 → in_rdy one cycle after acceptance, mem_en stays 0, exactly one pulse while in_en is held through the ready cycle.
- Conflict: with INDEX_WIDTH = 6, fetch 0x10 then 0x110 (same index, different tag) → both miss; a third fetch of 0x10 misses again.
- Flush mid-miss: miss on 0x20, assert flush for one cycle before mem_rdy → no in_rdy. mem_en held until mem_rdy. A later fetch of 0x20 hits with the drained data.
- Flush + mem_rdy same cycle: → no in_rdy, line filled, next request to the same address hits.
- Stall and reset: rdy_in low for 3 cycles around mem_rdy and the pulse → outputs frozen, one pulse after resume. Reset mid-miss → mem_en = 0 next cycle, a prior hit address now misses.

Source files
------------

// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icache_pkg
// Description : Shared definitions for the direct-mapped instruction cache.
//               It holds the default index width, the controller state
//               encoding and the tag-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package icache_pkg;

    // Default log2 of the line count
    localparam int ICACHE_INDEX_WIDTH = 6;

    // Controller states
    typedef enum logic [1:0] {
        ICACHE_IDLE  = 2'd0,
        ICACHE_MISS  = 2'd1,
        ICACHE_DRAIN = 2'd2
    } icache_state_t;

    // Tag width. A word address has 30 bits once the byte offset is dropped,
    // and the index takes the low bits of that word address.
    function automatic int icache_tag_width(input int index_width);
        return 30 - index_width;
    endfunction

endpackage : icache_pkg
`default_nettype wire

// File: rtl/icache_array.sv
`default_nettype none
// ============================================================================
// Module      : icache_array
// Description : Line storage for the instruction cache. Each line has a
//               valid bit, a tag and one 32-bit word. The read port is
//               combinational and the write port is synchronous. Reset
//               clears only the valid bits.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_array
    import icache_pkg::*;
#(
    parameter int INDEX_WIDTH = ICACHE_INDEX_WIDTH,
    parameter int TAG_WIDTH   = icache_tag_width(ICACHE_INDEX_WIDTH)
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [INDEX_WIDTH-1:0] i_rd_index,
    output logic                   o_rd_valid,
    output logic [TAG_WIDTH-1:0]   o_rd_tag,
    output logic [31:0]            o_rd_data,
    input  logic                   i_we,
    input  logic [INDEX_WIDTH-1:0] i_wr_index,
    input  logic [TAG_WIDTH-1:0]   i_wr_tag,
    input  logic [31:0]            i_wr_data
);

    localparam int c_DEPTH = 1 << INDEX_WIDTH;

    logic [c_DEPTH-1:0]   r_valid;
    logic [TAG_WIDTH-1:0] r_tag  [c_DEPTH];
    logic [31:0]          r_data [c_DEPTH];

    // Valid bits: cleared on reset and set when a line is filled
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_wr_index] <= 1'b1;
        end
    end

    // Tag and data storage. Contents are meaningless until the line is valid.
    always_ff @(posedge clk_in) begin
        if (i_we) begin
            r_tag[i_wr_index]  <= i_wr_tag;
            r_data[i_wr_index] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_data  = r_data[i_rd_index];

endmodule : icache_array
`default_nettype wire

// File: rtl/icache.sv
`default_nettype none
// ============================================================================
// Module      : icache
// Description : Direct-mapped instruction cache with one word per line. It
//               sits between the decoder fetch port and the memory word-read
//               port. A hit answers one cycle after the request is accepted.
//               A miss performs one memory read, fills the line and then
//               answers. A flush abandons the current request, but the memory
//               read that is already in flight still completes and fills the
//               line.
//               Optional macro ICACHE_STATS_EN adds saturating hit/miss
//               counters on ports stat_hits / stat_misses.
// Revision    : 1.0 - initial release
// ============================================================================
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_WIDTH = ICACHE_INDEX_WIDTH
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush,
    input  logic        in_en,
    input  logic [31:0] in_addr,
    output logic        in_rdy,
    output logic [31:0] in_data,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    input  logic        mem_rdy,
    input  logic [31:0] mem_data
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_misses
`endif
);

    localparam int c_TAG_WIDTH = icache_tag_width(INDEX_WIDTH);

    icache_state_t            r_state;
    logic                     r_in_rdy;
    logic [31:0]              r_in_data;
    logic                     r_mem_en;
    logic [31:0]              r_mem_addr;

    logic                     w_rd_valid;
    logic [c_TAG_WIDTH-1:0]   w_rd_tag;
    logic [31:0]              w_rd_data;
    logic                     w_hit;
    logic                     w_accept;
    logic                     w_fill;
    logic                     w_unused;

    // The byte offset of a fetch address has no meaning for word-aligned code
    assign w_unused = ^in_addr[1:0];

    // Lookup uses the live decoder address. It only matters in IDLE.
    // Fills use the latched miss address, which is held in r_mem_addr.
    icache_array #(
        .INDEX_WIDTH (INDEX_WIDTH),
        .TAG_WIDTH   (c_TAG_WIDTH)
    ) u_array (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .i_rd_index (in_addr[INDEX_WIDTH+1:2]),
        .o_rd_valid (w_rd_valid),
        .o_rd_tag   (w_rd_tag),
        .o_rd_data  (w_rd_data),
        .i_we       (w_fill && !rst_in),
        .i_wr_index (r_mem_addr[INDEX_WIDTH+1:2]),
        .i_wr_tag   (r_mem_addr[31:INDEX_WIDTH+2]),
        .i_wr_data  (mem_data)
    );

    assign w_hit    = w_rd_valid && (w_rd_tag == in_addr[31:INDEX_WIDTH+2]);
    // The r_in_rdy term stops a second pulse while the decoder still holds in_en
    assign w_accept = rdy_in && (r_state == ICACHE_IDLE) && in_en && !flush && !r_in_rdy;
    assign w_fill   = rdy_in && (r_state != ICACHE_IDLE) && mem_rdy;

    // Request/miss controller with registered decoder and memory outputs
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= ICACHE_IDLE;
            r_in_rdy   <= 1'b0;
            r_in_data  <= 32'd0;
            r_mem_en   <= 1'b0;
            r_mem_addr <= 32'd0;
        end else if (rdy_in) begin
            r_in_rdy <= 1'b0;
            case (r_state)
                ICACHE_IDLE: begin
                    if (w_accept) begin
                        if (w_hit) begin
                            r_in_rdy  <= 1'b1;
                            r_in_data <= w_rd_data;
                        end else begin
                            r_mem_en   <= 1'b1;
                            r_mem_addr <= {in_addr[31:2], 2'b00};
                            r_state    <= ICACHE_MISS;
                        end
                    end
                end
                ICACHE_MISS: begin
                    if (mem_rdy) begin
                        r_mem_en <= 1'b0;
                        r_state  <= ICACHE_IDLE;
                        // A flush in the same cycle keeps the fill but drops the answer
                        if (!flush) begin
                            r_in_rdy  <= 1'b1;
                            r_in_data <= mem_data;
                        end
                    end else if (flush) begin
                        r_state <= ICACHE_DRAIN;
                    end
                end
                ICACHE_DRAIN: begin
                    // The read completes for a request nobody wants any more
                    if (mem_rdy) begin
                        r_mem_en <= 1'b0;
                        r_state  <= ICACHE_IDLE;
                    end
                end
                default: begin
                    r_state <= ICACHE_IDLE;
                end
            endcase
        end
    end

    assign in_rdy   = r_in_rdy;
    assign in_data  = r_in_data;
    assign mem_en   = r_mem_en;
    assign mem_addr = r_mem_addr;

`ifdef ICACHE_STATS_EN
    logic [31:0] r_stat_hits;
    logic [31:0] r_stat_misses;

    // Saturating event counters. They are frozen with the rest of the block.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_stat_hits   <= 32'd0;
            r_stat_misses <= 32'd0;
        end else begin
            if (w_accept && w_hit && (r_stat_hits != 32'hFFFF_FFFF)) begin
                r_stat_hits <= r_stat_hits + 32'd1;
            end
            if (w_accept && !w_hit && (r_stat_misses != 32'hFFFF_FFFF)) begin
                r_stat_misses <= r_stat_misses + 32'd1;
            end
        end
    end

    assign stat_hits   = r_stat_hits;
    assign stat_misses = r_stat_misses;
`endif

endmodule : icache
`default_nettype wire
